timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU data bus.
- The `mips` core is the bus initiator; this block is the bus responder.
- The CPU programs it with stores, reads status with loads, and receives an interrupt request.
- Sits beside data memory behind the bridge address decode in the CPU top level.

Parameters:
- WIDTH, 32, data/register width.
- DEF_PRESET, 0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- addr  input  4  byte offset within the timer window; only addr[3:2] is decoded.
- we  input  1  write strobe from the bridge; sampled at the rising edge.
- din  input  WIDTH  write data.
- dout  output  WIDTH  combinational read data.
- irq  output  1  interrupt request to the CPU.

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is asynchronous and active-high.
- Register map:
  - 0x0 CTRL (R/W): bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled), bits31:4 read 0.
  - 0x4 PRESET (R/W).
  - 0x8 COUNT (read-only; writes ignored).
  - 0xC reads 0; writes ignored.
- dout = selected register, combinational, zero latency.
- Write takes effect at the rising edge with we=1.
- Reset values: CTRL=0, PRESET=DEF_PRESET, COUNT=0, state=IDLE, pending=0, dout per map, irq=0.
- State machine, one transition per cycle:
  - IDLE: if EN -> LOAD; else hold.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - if !EN -> IDLE, COUNT holds its value (pause; re-enable reloads PRESET).
    - else if COUNT<=1: COUNT<=0, pending<=1, -> INT.
    - else COUNT<=COUNT-1.
  - INT: MODE 00 -> EN<=0, -> IDLE. MODE 01 -> LOAD.
- irq = pending & IM.
- pending clearing:
  - MODE 00: pending stays 1 until any CPU write to CTRL.
  - MODE 01: pending is a one-cycle pulse, cleared at the edge after it is set.
- Timing:
  - CTRL write enabling at edge 0: LOAD at edge 1, COUNT=P at edge 2, pending set at edge P+2 (P>=1); P=0 gives pending at edge 3.
  - Auto-reload period: P+2 cycles between pulses.
- Simultaneous events:
  - CPU CTRL write on the same edge INT clears EN: the CPU write wins (EN takes din[0]).
  - CTRL write on the same edge pending would be set: set wins.
- PRESET write during CNT: no effect on the current count; used at the next LOAD.
- Reset asserted mid-count: everything returns to reset values without waiting for a clock edge.
- Arithmetic: COUNT is unsigned WIDTH bits and never wraps below 0.

Decomposition:
- Shared package (timer_pkg): register offsets (CTRL/PRESET/COUNT), CTRL bit positions, MODE codes, 2-bit state encodings (IDLE=0, LOAD=1, CNT=2, INT=3).
- No sub-module; register file and FSM fit in a single module of about 150 lines.

Test Plan:
- Reset release, no writes -> dout reads 0 at 0x0 and 0x8, irq=0; DEF_PRESET read at 0x4.
- PRESET=5, CTRL=0b1001 (EN, one-shot, IM) at edge 0 -> COUNT reads 5 after edge 2, 1 after edge 6, irq=1 after edge 7 and stays high; EN reads 0; writing CTRL=0 drops irq next edge.
- PRESET=3, CTRL=0b1011 (auto-reload) -> irq single-cycle pulses every 5 cycles, at least 4 pulses checked; COUNT sequence 3,2,1,0,(LOAD),3,...
- One-shot with IM=0, PRESET=2 -> irq stays 0, pending observable; CTRL write with IM=1 and EN=0 clears pending, so irq never rises.
- Mid-count CTRL=0 at COUNT=4 -> COUNT holds 4, state IDLE; re-enable reloads PRESET. Write 0x1234 to 0x8 -> COUNT unchanged.
- Assert reset asynchronously (between edges) while COUNT=7, MODE 01 -> COUNT, CTRL, irq go to 0 immediately, no pulse after release.

Source files
------------

// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : register offsets, CTRL fields, MODE codes and FSM states
//             shared by the countdown timer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  // Word index within the timer window, taken from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_dev.sv
// ============================================================================
// timer_dev : memory-mapped countdown timer (CTRL/PRESET/COUNT) with irq
// Revision  : 1.0
// ============================================================================
`default_nettype none

module timer_dev
  import timer_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DEF_PRESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pending_q, pending_d;

  logic             ctrl_wr;
  logic             preset_wr;
  logic             auto_reload;
  logic             set_pending;
  logic             unused_addr;

  assign ctrl_wr     = we && (addr[3:2] == REG_CTRL);
  assign preset_wr   = we && (addr[3:2] == REG_PRESET);
  assign auto_reload = (mode_q == MODE_AUTO);
  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= DEF_PRESET;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    mode_d      = mode_q;
    im_d        = im_q;
    preset_d    = preset_q;
    count_d     = count_q;
    pending_d   = pending_q;
    set_pending = 1'b0;

    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q <= WIDTH'(1)) begin
          count_d     = '0;
          set_pending = 1'b1;
          state_d     = ST_INT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Later assignments take priority: CPU write beats the FSM, a new set beats any clear
    if (pending_q && auto_reload) pending_d = 1'b0;
    if (ctrl_wr) begin
      en_d      = din[CTRL_EN];
      mode_d    = din[CTRL_MODE_HI:CTRL_MODE_LO];
      im_d      = din[CTRL_IM];
      pending_d = 1'b0;
    end
    if (set_pending) pending_d = 1'b1;
    if (preset_wr) preset_d = din;
  end

  always_comb begin
    dout = '0;
    case (addr[3:2])
      REG_CTRL: begin
        dout[CTRL_EN]                    = en_q;
        dout[CTRL_MODE_HI:CTRL_MODE_LO]  = mode_q;
        dout[CTRL_IM]                    = im_q;
      end
      REG_PRESET: dout = preset_q;
      REG_COUNT:  dout = count_q;
      default:    dout = '0;
    endcase
  end

  assign irq = pending_q & im_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ============================================================================
// tb_timer_dev : directed scoreboard bench for the countdown timer
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_timer_dev;
  import timer_pkg::*;

  localparam logic [31:0] DEFP = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic        we = 1'b0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        irq;

  int          total = 0;
  int          bad = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  timer_dev #(.WIDTH(32), .DEF_PRESET(DEFP)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr = a; #1;
    v = dout;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    val_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: observed=%h expected=queued_value", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int          off;

    // Reset and idle register map
    #23 reset = 1'b0;
    tick();
    push("rst_ctrl", 32'h0);   rd(4'h0, v); check(v);
    push("rst_count", 32'h0);  rd(4'h8, v); check(v);
    push("rst_preset", DEFP);  rd(4'h4, v); check(v);
    push("rst_irq", 32'h0);    check({31'b0, irq});

    // One-shot, PRESET=5, IM=1
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);                       // edge 0
    tick(); tick();                        // edge 2
    push("os_count_e2", 32'd5); rd(4'h8, v); check(v);
    repeat (4) tick();                     // edge 6
    push("os_count_e6", 32'd1); rd(4'h8, v); check(v);
    push("os_irq_e6", 32'd0);   check({31'b0, irq});
    tick();                                // edge 7
    push("os_irq_e7", 32'd1);   check({31'b0, irq});
    push("os_count_e7", 32'd0); rd(4'h8, v); check(v);
    tick();                                // edge 8
    push("os_ctrl_en_off", 32'h8); rd(4'h0, v); check(v);
    tick(); tick();
    push("os_irq_held", 32'd1); check({31'b0, irq});
    wr(4'h0, 32'h0);
    push("os_irq_cleared", 32'd0); check({31'b0, irq});

    // Auto-reload, PRESET=3: pulse every 5 cycles
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);                       // edge 0
    for (int k = 1; k <= 22; k++) begin
      push("ar_irq", (k % 5 == 0) ? 32'd1 : 32'd0);
      off = (k - 2) % 5;
      push("ar_count", (k >= 2 && off < 3) ? 32'(3 - off) : 32'd0);
      tick();
      check({31'b0, irq});
      rd(4'h8, v); check(v);
    end
    wr(4'h0, 32'h0);
    tick();

    // One-shot with IM=0: pending without irq, cleared by a CTRL write
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);                       // edge 0
    repeat (4) tick();                     // edge 4
    push("im0_pending", 32'd1); check({31'b0, dut.pending_q});
    push("im0_irq", 32'd0);     check({31'b0, irq});
    tick();                                // edge 5
    push("im0_ctrl", 32'h0);    rd(4'h0, v); check(v);
    wr(4'h0, 32'h8);                       // edge 6
    push("im0_pending_clr", 32'd0); check({31'b0, dut.pending_q});
    for (int k = 0; k < 3; k++) begin
      push("im0_irq_low", 32'd0);
      check({31'b0, irq});
      tick();
    end
    wr(4'h0, 32'h0);

    // Pause mid-count, ignored writes, re-enable, PRESET change during CNT
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);                       // edge 0
    repeat (7) tick();                     // edge 7
    push("pause_count_e7", 32'd5); rd(4'h8, v); check(v);
    wr(4'h0, 32'h0);                       // edge 8
    push("pause_count_e8", 32'd4); rd(4'h8, v); check(v);
    tick();
    push("pause_state", 32'(ST_IDLE)); check(32'(dut.state_q));
    tick();
    push("pause_hold", 32'd4); rd(4'h8, v); check(v);
    wr(4'h8, 32'h1234);
    push("count_ro", 32'd4); rd(4'h8, v); check(v);
    wr(4'hC, 32'hFFFF_FFFF);
    push("reg_c_zero", 32'h0); rd(4'hC, v); check(v);
    push("ctrl_after_c", 32'h0); rd(4'h0, v); check(v);
    wr(4'h0, 32'h1);                       // edge 0
    tick(); tick();                        // edge 2
    push("reenable_reload", 32'd10); rd(4'h8, v); check(v);
    wr(4'h4, 32'd20);                      // edge 3
    push("preset_in_cnt", 32'd9); rd(4'h8, v); check(v);
    tick();
    push("preset_in_cnt2", 32'd8); rd(4'h8, v); check(v);
    push("preset_readback", 32'd20); rd(4'h4, v); check(v);
    wr(4'h0, 32'h0);
    tick();

    // PRESET=0 fires at edge 3
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);                       // edge 0
    tick(); tick();                        // edge 2
    push("p0_irq_e2", 32'd0); check({31'b0, irq});
    tick();                                // edge 3
    push("p0_irq_e3", 32'd1); check({31'b0, irq});
    wr(4'h0, 32'h0);
    tick();

    // CPU write beats INT's EN clear; pending set beats a CTRL write clear
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h9);                       // edge 0
    tick(); tick(); tick();                // edge 3
    push("sim_irq_e3", 32'd1); check({31'b0, irq});
    wr(4'h0, 32'h9);                       // edge 4
    push("sim_cpu_wins", 32'h9); rd(4'h0, v); check(v);
    push("sim_irq_e4", 32'd0);   check({31'b0, irq});
    tick(); tick();                        // edge 6
    wr(4'h0, 32'h9);                       // edge 7
    push("sim_set_wins", 32'd1); check({31'b0, irq});
    tick();                                // edge 8
    push("sim_ctrl_e8", 32'h8); rd(4'h0, v); check(v);
    wr(4'h0, 32'h0);
    tick();

    // Asynchronous reset mid-count in auto-reload mode
    wr(4'h4, 32'd9);
    wr(4'h0, 32'hB);                       // edge 0
    repeat (4) tick();                     // edge 4
    push("ar_rst_pre", 32'd7); rd(4'h8, v); check(v);
    #3 reset = 1'b1;
    #1;
    push("async_count", 32'h0);  rd(4'h8, v); check(v);
    push("async_ctrl", 32'h0);   rd(4'h0, v); check(v);
    push("async_irq", 32'h0);    check({31'b0, irq});
    push("async_preset", DEFP);  rd(4'h4, v); check(v);
    #2 reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      push("post_rst_irq", 32'd0);
      tick();
      check({31'b0, irq});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
